// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field input handshake, word output stream and illegal-mnemonic status
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err_illegal;
    logic [7:0]  illegal_cnt;
    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_word, out_addr, err_illegal, illegal_cnt
    );
    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_word, out_addr, err_illegal, illegal_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS subset instructions into a FIFO streamed out with byte addresses
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    input logic             flush,
    instr_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [5:0] op, funct;
    logic [31:0] word, addr;
    logic legal, accept, push, pop, err;
    logic [7:0] icnt;
    always_comb begin
        op = 6'h00;
        funct = 6'h00;
        case (bus.in_mnem)
            4'd0: funct = 6'h20;
            4'd1: funct = 6'h22;
            4'd2: funct = 6'h24;
            4'd3: funct = 6'h25;
            4'd4: funct = 6'h2A;
            4'd5: funct = 6'h2B;
            4'd6: funct = 6'h21;
            4'd7: funct = 6'h23;
            4'd8: op = 6'h08;
            4'd9: op = 6'h0D;
            4'd10: op = 6'h23;
            4'd11: op = 6'h2B;
            4'd12: op = 6'h04;
            4'd13: op = 6'h02;
            default: ;
        endcase
        word = bus.in_mnem < 4'd8 ? {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, funct}
             : bus.in_mnem == 4'd13 ? {op, bus.in_target}
             : {op, bus.in_rs, bus.in_rt, bus.in_imm};
    end
    // full exactly when count reaches DEPTH, i.e. its top bit is set
    assign bus.in_ready = !count[AW];
    assign bus.out_valid = |count;
    assign legal = bus.in_mnem < 4'd14;
    assign accept = bus.in_valid & bus.in_ready & !flush;
    assign push = accept & legal;
    assign pop = bus.out_valid & bus.out_ready & !flush;
    assign bus.out_word = bus.out_valid ? mem[rp] : 32'h0;
    assign bus.out_addr = addr;
    assign bus.err_illegal = err;
    assign bus.illegal_cnt = icnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            addr <= BASE_ADDR;
            err <= 1'b0;
            icnt <= 8'h00;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            addr <= BASE_ADDR;
            err <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                addr <= addr + 32'd4;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            err <= accept & !legal;
            if (accept & !legal & icnt != 8'hFF) icnt <= icnt + 8'h01;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= word;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed scoreboard bench for instr_encoder
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    logic [31:0] exp_addr = BASE;
    logic exp_err = 1'b0;
    int exp_cnt = 0;
    logic [31:0] first;
    instr_encoder_if bus();
    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(int m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [15:0] imm, logic [25:0] t);
        int funct[8] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h2B, 32'h21, 32'h23};
        int opc[5] = '{32'h08, 32'h0D, 32'h23, 32'h2B, 32'h04};
        if (m < 8) return (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'(funct[m]);
        if (m == 13) return (32'd2 << 26) + 32'(t);
        return (32'(opc[m-8]) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic drive(int m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [15:0] imm, logic [25:0] t);
        bus.in_valid = 1'b1;
        bus.in_mnem = 4'(m);
        bus.in_rs = rs;
        bus.in_rt = rt;
        bus.in_rd = rd;
        bus.in_imm = imm;
        bus.in_target = t;
    endtask

    task automatic drive_rand(int lo, int hi);
        drive($urandom_range(hi, lo), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // reference model: queue of expected words, address and illegal status from the rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_addr = BASE;
            exp_err = 1'b0;
            exp_cnt = 0;
        end else if (flush) begin
            q.delete();
            exp_addr = BASE;
            exp_err = 1'b0;
        end else begin
            automatic bit rdy = q.size() < DEPTH;
            automatic bit do_pop = q.size() > 0 && bus.out_ready;
            exp_err = 1'b0;
            if (do_pop) begin
                void'(q.pop_front());
                exp_addr = exp_addr + 32'd4;
            end
            if (bus.in_valid && rdy) begin
                if (bus.in_mnem >= 4'd14) begin
                    exp_err = 1'b1;
                    if (exp_cnt < 255) exp_cnt++;
                end else q.push_back(enc(int'(bus.in_mnem), bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, bus.in_target));
            end
        end
    end

    // monitor: compares DUT outputs with the model away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
            chk("out_addr", bus.out_addr, exp_addr);
            chk("err_illegal", 32'(bus.err_illegal), 32'(exp_err));
            chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(exp_cnt));
            chk("out_word", bus.out_word, q.size() != 0 ? q[0] : 32'h0);
        end
    end

    initial begin
        idle();
        bus.in_mnem = 4'd0;
        bus.in_rs = 5'd0;
        bus.in_rt = 5'd0;
        bus.in_rd = 5'd0;
        bus.in_imm = 16'd0;
        bus.in_target = 26'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_word", bus.out_word, 32'd0);
        chk("rst_addr", bus.out_addr, BASE);
        chk("rst_cnt", 32'(bus.illegal_cnt), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        @(negedge clk);
        idle();
        chk("add_word", bus.out_word, 32'h00221820);
        chk("add_addr", bus.out_addr, 32'h0);
        @(negedge clk);
        drive(8, 5'd0, 5'd1, 5'd0, 16'd5, 26'd0);
        @(negedge clk);
        idle();
        chk("addi_word", bus.out_word, 32'h20010005);
        chk("addi_addr", bus.out_addr, 32'h4);
        @(negedge clk);
        drive(13, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100);
        chk("j_pre_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        idle();
        chk("j_valid", 32'(bus.out_valid), 32'd1);
        chk("j_word", bus.out_word, 32'h08000100);
        @(negedge clk);
        chk("j_gone", 32'(bus.out_valid), 32'd0);
        do_flush();
        drive(10, 5'd1, 5'd2, 5'd0, 16'd8, 26'd0);
        @(negedge clk);
        drive(11, 5'd1, 5'd2, 5'd0, 16'd8, 26'd0);
        chk("lw_word", bus.out_word, 32'h8C220008);
        chk("lw_addr", bus.out_addr, 32'h0);
        @(negedge clk);
        drive(12, 5'd1, 5'd2, 5'd0, 16'hFFFC, 26'd0);
        chk("sw_word", bus.out_word, 32'hAC220008);
        chk("sw_addr", bus.out_addr, 32'h4);
        @(negedge clk);
        idle();
        chk("beq_word", bus.out_word, 32'h1022FFFC);
        chk("beq_addr", bus.out_addr, 32'h8);
        do_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) chk("full_ready", 32'(bus.in_ready), 32'd0);
            drive_rand(0, 13);
            if (i == 0) first = enc(int'(bus.in_mnem), bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, bus.in_target);
        end
        @(negedge clk);
        idle();
        chk("bp_head", bus.out_word, first);
        chk("bp_addr", bus.out_addr, BASE);
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        do_flush();
        drive(9, 5'd0, 5'd4, 5'd0, 16'h00FF, 26'd0);
        @(negedge clk);
        drive(14, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        chk("ori1_word", bus.out_word, 32'h340400FF);
        @(negedge clk);
        drive(9, 5'd1, 5'd5, 5'd0, 16'h1234, 26'd0);
        chk("ill_err", 32'(bus.err_illegal), 32'd1);
        chk("ill_cnt", 32'(bus.illegal_cnt), 32'd1);
        @(negedge clk);
        idle();
        chk("ill_err_end", 32'(bus.err_illegal), 32'd0);
        chk("ori2_word", bus.out_word, 32'h34251234);
        chk("ori2_addr", bus.out_addr, 32'h4);
        do_flush();
        bus.out_ready = 1'b0;
        repeat (2) begin
            drive_rand(0, 13);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rand(0, 13);
            @(negedge clk);
            chk("conc_ready", 32'(bus.in_ready), 32'd1);
        end
        idle();
        bus.out_ready = 1'b0;
        repeat (3) begin
            drive_rand(0, 13);
            @(negedge clk);
        end
        flush = 1'b1;
        drive_rand(0, 13);
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_addr", bus.out_addr, BASE);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) != 0) drive_rand(0, 15);
            else idle();
            bus.out_ready = 1'($urandom);
            flush = $urandom_range(24, 0) == 0;
            @(negedge clk);
        end
        flush = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            drive_rand(14, 15);
            @(negedge clk);
        end
        idle();
        chk("sat_cnt", 32'(bus.illegal_cnt), 32'd255);
        bus.out_ready = 1'b0;
        repeat (3) begin
            drive_rand(0, 13);
            @(negedge clk);
        end
        idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_word", bus.out_word, 32'd0);
        chk("arst_addr", bus.out_addr, BASE);
        chk("arst_err", 32'(bus.err_illegal), 32'd0);
        chk("arst_cnt", 32'(bus.illegal_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) begin
            drive_rand(0, 15);
            @(negedge clk);
        end
        idle();
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes MIPS instructions for the single-cycle CPU subset. Takes a mnemonic ID plus register, immediate and target fields and produces 32-bit instruction words. This is the inverse of the control decoder.
- Encoded words are buffered in a small FIFO and streamed out with a word address. They feed the instruction-memory loader or a testbench checker.
- Supported subset: add, sub, and, or, slt, sltu, addu, subu, addi, ori, lw, sw, beq, j.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address paired with the first output word, and restored on flush.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of FIFO and address
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept; equals (count < DEPTH)
- in_mnem  in  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu, 6 addu, 7 subu, 8 addi, 9 ori, 10 lw, 11 sw, 12 beq, 13 j, 14-15 illegal
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field (R-type only)
- in_imm  in  16  immediate or offset (I-type only)
- in_target  in  26  jump target (j only)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head word
- out_word  out  32  head instruction word
- out_addr  out  32  byte address of the head word
- err_illegal  out  1  one-cycle pulse when an illegal mnemonic is accepted
- illegal_cnt  out  8  illegal mnemonics accepted; saturates at 255

Behaviour:
- Reset (async, rst=1): FIFO empty, count=0, out_valid=0, out_word=0, out_addr=BASE_ADDR, err_illegal=0, illegal_cnt=0. Reset asserted mid-stream discards all buffered words.
- Encoding (combinational from the inputs):
  - R-type: op=0, {rs, rt, rd}, shamt=0. funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sltu 0x2B, addu 0x21, subu 0x23.
  - I-type: {op, rs, rt, imm}. op: addi 0x08, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04.
  - j: {6'h02, target}.
  - Unused fields are ignored.
- Push: on a rising edge with in_valid & in_ready and a legal mnemonic, the encoded word is written at the tail and count increments.
- Illegal mnemonic (14-15): handshake completes and nothing is written. err_illegal=1 for exactly the next cycle. illegal_cnt increments unless already 255.
- Pop: on a rising edge with out_valid & out_ready, the head advances, count decrements, and out_addr += 4, wrapping modulo 2^32.
- out_word and out_addr always show the head entry. When the FIFO is empty, out_word = 0.
- Latency: a legal word accepted into an empty FIFO appears with out_valid=1 on the cycle after acceptance. Words are never forwarded combinationally.
- Simultaneous push and pop when not empty: count is unchanged and both pointers advance.
  - When full, in_ready=0 even if a pop occurs in the same cycle (no bypass).
  - When empty, a pop cannot occur because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- flush=1 (synchronous) has priority over push and pop:
  - count=0, pointers=0, out_addr=BASE_ADDR.
  - An input handshaken in the same cycle is dropped.
  - illegal_cnt is retained. err_illegal is forced to 0 next cycle.
- out_word and out_addr must not change while out_valid=1 and out_ready=0.

Test Plan:
- Single-word encodes, each entry into an empty FIFO, out_ready=1:
  - add rs=1 rt=2 rd=3 -> 0x00221820, out_addr 0x0
  - addi rs=0 rt=1 imm=5 -> 0x20010005, out_addr 0x4
  - j target=0x100 -> 0x08000100, out_valid exactly one cycle after acceptance
- Memory and branch encodes: lw rs=1 rt=2 imm=8 -> 0x8C220008; sw with the same fields -> 0xAC220008; beq rs=1 rt=2 imm=0xFFFC -> 0x1022FFFC. out_addr values 0x0, 0x4, 0x8.
- Backpressure: out_ready=0, push 5 legal words -> in_ready drops after the 4th. Head stays the 1st word. Raising out_ready drains words 1-4 in order at addresses BASE, +4, +8, +12.
- Illegal mnemonic: push mnem=14 between two ori words -> err_illegal pulses one cycle, illegal_cnt=1, and only the two ori words (e.g. rs=0 rt=4 imm=0x00FF -> 0x340400FF) come out, at consecutive addresses.
- Concurrent traffic: with 2 words queued, push and pop every cycle for 10 cycles -> count stays 2, order is preserved, addresses advance by 4 per pop.
- Flush and reset: with 3 words queued, flush=1 with in_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR, input dropped. Asserting rst asynchronously mid-stream -> outputs return to reset values immediately.
